// File: rtl/pic_pkg.sv
// pic_pkg: shared OCW2 command codes, level type and helpers for the PIC priority resolver
package pic_pkg;
  typedef logic [2:0] level_t;
  localparam level_t SPURIOUS_LEVEL = 3'd7;
  localparam logic [2:0] OCW2_AUTO_ROT_OFF = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_AUTO_ROT_ON  = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;
  // Rank 0 is the highest priority: the level just above the lowest-priority level lp.
  function automatic level_t prio_rank(level_t l, level_t lp);
    return l - lp - 3'd1;
  endfunction
endpackage

// File: rtl/pic_prio_find.sv
// pic_prio_find: highest-priority set bit of an 8-bit vector under rotating priority (lp lowest)
module pic_prio_find
  import pic_pkg::*;
(
  input  logic [7:0] vec,
  input  level_t     lp,
  output logic       valid,
  output level_t     level
);
  assign valid = |vec;
  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    level = '0;
    for (int i = 7; i >= 0; i--)
      if (vec[3'(lp + 3'(i) + 3'd1)]) level = 3'(lp + 3'(i) + 3'd1);
  end
endmodule

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: 8259-style IRR/ISR priority resolver; rotation enabled by macro PIC_ROTATE_EN
module pic_priority_resolver
  import pic_pkg::*;
#(
  parameter level_t RESET_LP = 3'd7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ir,
  input  logic [7:0] mask,
  input  logic       aeoi,
  input  logic       ocw2_valid,
  input  logic [2:0] ocw2_cmd,
  input  logic [2:0] ocw2_level,
  input  logic       inta_ack1,
  input  logic       inta_ack2,
  output logic       intreq,
  output level_t     vector_level,
  output logic [7:0] irr,
  output logic [7:0] isr
);
  logic [7:0] ir_q;
  logic [7:0] grant_bit;
  logic [7:0] isr_clr;
  level_t     lp;
  level_t     cand;
  level_t     isr_top;
  level_t     eoi_level;
  logic       cand_valid;
  logic       isr_valid;
  logic       grant;
  logic       ns_eoi;
  logic       sp_eoi;
  logic       eoi;
  pic_prio_find u_cand_find (.vec(irr & ~mask), .lp(lp), .valid(cand_valid), .level(cand));
  pic_prio_find u_isr_find  (.vec(isr),         .lp(lp), .valid(isr_valid),  .level(isr_top));
  assign grant     = inta_ack1 && cand_valid;
  assign grant_bit = grant ? 8'b1 << cand : 8'h00;
  assign ns_eoi    = ocw2_cmd == OCW2_NS_EOI || ocw2_cmd == OCW2_ROT_NS_EOI;
  assign sp_eoi    = ocw2_cmd == OCW2_SP_EOI || ocw2_cmd == OCW2_ROT_SP_EOI;
  assign eoi       = ocw2_valid && (ns_eoi || sp_eoi) && isr_valid;
  assign eoi_level = sp_eoi ? ocw2_level : isr_top;
  assign isr_clr   = (eoi ? 8'b1 << eoi_level : 8'h00) | (inta_ack2 && aeoi ? 8'b1 << vector_level : 8'h00);
  // Request/service registers; new edges and new grants override same-cycle clears.
  always_ff @(posedge clk)
    if (rst) begin
      ir_q         <= 8'hFF;
      irr          <= 8'h00;
      isr          <= 8'h00;
      intreq       <= 1'b0;
      vector_level <= '0;
    end else begin
      ir_q   <= ir;
      irr    <= (irr & ~grant_bit) | (ir & ~ir_q);
      isr    <= (isr & ~isr_clr) | grant_bit;
      intreq <= !grant && cand_valid && (!isr_valid || prio_rank(cand, lp) < prio_rank(isr_top, lp));
      if (inta_ack1) vector_level <= grant ? cand : SPURIOUS_LEVEL;
    end
`ifdef PIC_ROTATE_EN
  logic auto_rot;
  // Lowest-priority level moves on rotating EOIs, explicit set-priority, or automatic rotation at AEOI.
  always_ff @(posedge clk)
    if (rst) begin
      lp       <= RESET_LP;
      auto_rot <= 1'b0;
    end else begin
      if (eoi && ocw2_cmd[2]) lp <= eoi_level;
      else if (ocw2_valid && ocw2_cmd == OCW2_SET_PRIO) lp <= ocw2_level;
      else if (inta_ack2 && aeoi && auto_rot) lp <= vector_level;
      if (ocw2_valid && ocw2_cmd == OCW2_AUTO_ROT_ON) auto_rot <= 1'b1;
      else if (ocw2_valid && ocw2_cmd == OCW2_AUTO_ROT_OFF) auto_rot <= 1'b0;
    end
`else
  assign lp = RESET_LP;
`endif
endmodule
